mult_share_arb: RTL and testbench
=================================

// Module: mult_share_arb
// PURPOSE
//  Shares one fixed-latency, non-stallable 8x8 array multiplier among N_REQ requesters.
//  The multiplier has registered partial products followed by a combinational adder tree.
//  Round-robin arbitration accepts one operand pair per cycle and drives the multiplier inputs.
//  An ID tag travels alongside each operation so that every product returns to the right requester.
//  A hold/drain state machine lets the system quiesce the shared multiplier.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  ID_W     2   requester-ID width, equal to clog2(N_REQ)
//  W        8   operand width; product width is 2*W
//  MUL_LAT  1   multiplier latency: mul_p in cycle t+MUL_LAT is the product of mul_a/mul_b in cycle t
// PORTS
//  clk        in   1        rising-edge clock, the only clock
//  reset      in   1        synchronous, active-high reset
//  req        in   N_REQ    req[i]=1: requester i holds a valid operand pair
//  req_a      in   N_REQ*W  operand A; requester i uses bits [W*i+W-1:W*i]
//  req_b      in   N_REQ*W  operand B; same packing as req_a
//  gnt        out  N_REQ    one-hot accept, combinational; operands are taken in this cycle
//  hold       in   1        1 = stop granting and drain the multiplier
//  mul_a      out  W        multiplier operand A (granted requester's req_a, else 0)
//  mul_b      out  W        multiplier operand B (granted requester's req_b, else 0)
//  mul_p      in   2*W      multiplier product
//  res_valid  out  1        registered one-cycle pulse: res_p/res_id are valid
//  res_id     out  ID_W     requester that owns res_p
//  res_p      out  2*W      product
//  busy       out  1        any operation in flight (tag pipe or output register)
//  idle       out  1        state==HALT
//  op_cnt     out  16       count of grants issued; wraps 0xFFFF -> 0
// BEHAVIOUR
//  Handshake
//   - A requester holds req and its operands stable until it sees gnt[i]=1 in the same cycle.
//   - req may fall only after the grant. No result backpressure: the multiplier cannot stall.
//  Arbitration
//   - ptr (ID_W bits) marks the highest-priority requester. Search order is ptr, ptr+1, ..., wrapping mod N_REQ.
//   - On a grant to i, ptr <= (i+1) mod N_REQ. With no grant, ptr is unchanged.
//   - At most one gnt bit is set per cycle. gnt is all zero when hold=1 or state!=RUN, even in the same cycle as req.
//  Tag pipe
//   - MUL_LAT stages of {valid,id}. Stage 0 loads {|gnt, granted id}.
//   - The last stage is aligned with mul_p.
//   - At the next edge: res_valid <= last.valid, res_id <= last.id, res_p <= mul_p.
//   - When last.valid=0, res_id and res_p hold their previous values.
//   - Latency from a grant in cycle t to res_valid=1 is cycle t+MUL_LAT+1.
//   - Results return in grant order. Peak throughput is 1 op/cycle.
//  FSM (state register)
//   - RUN: grants allowed. hold=1 -> DRAIN.
//   - DRAIN: no grants. hold=0 -> RUN. Else, when !busy -> HALT.
//   - HALT: no grants. hold=0 -> RUN. Grants resume in the cycle after entering RUN.
//   - hold=0 overrides the drain-complete condition in DRAIN.
//  Flags
//   - busy = OR of all tag-stage valids and res_valid.
//   - op_cnt increments by 1 on every cycle with |gnt.
//  Reset (applies mid-operation as well)
//   - All outputs go to 0, ptr=0, state=RUN, tag pipe cleared.
//   - In-flight operations are discarded and produce no res_valid.
//   - Requesters still asserting req are re-arbitrated starting at ptr=0.
//  Width rules
//   - Products are unsigned, 2*W bits, and never truncated.
// TESTING
//  Bench model: multiplier that registers its operands and delivers a*b after MUL_LAT cycles.
//  1. After reset, req=0001 with a0=b0=8'hFF -> gnt=0001 in cycle 0.
//     res_valid=1, res_id=0, res_p=16'hFE01 in cycle 2; op_cnt=1.
//  2. req=1111 held 8 cycles, a_i=i+1, b_i=3 -> gnt order 0,1,2,3,0,1,2,3.
//     res_p sequence 3,6,9,12 repeated, with matching res_id, starting in cycle 2.
//  3. req=0101 held -> grants alternate 0,2,0,2. Requesters 1 and 3 are never granted.
//  4. RUN with 1 op in flight, then hold=1 -> gnt=0 in that cycle; in-flight result still emitted.
//     busy falls and idle=1 follows within 3 cycles.
//     hold=0 -> gnt resumes the cycle after RUN is entered.
//  5. reset=1 while res_valid would be due next cycle -> no res_valid.
//     All outputs 0; req=1000 re-granted 1 cycle after reset falls.
//  6. MUL_LAT=3 build, back-to-back grants -> res_valid 4 cycles after each gnt, in order.
//     Also run 65536 grants -> op_cnt wraps to 0.

Source files
------------

// File: rtl/mult_share_arb_if.sv
// Requester and multiplier-side bus of the shared multiplier arbiter.
interface mult_share_arb_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned W     = 8
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   gnt;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic [2*W-1:0]     mul_p;
  logic               res_valid;
  logic [ID_W-1:0]    res_id;
  logic [2*W-1:0]     res_p;

  // Environment side: requesters plus the external multiplier
  modport master (
    output req, req_a, req_b, mul_p,
    input  gnt, mul_a, mul_b, res_valid, res_id, res_p
  );

  // Arbiter side
  modport slave (
    input  req, req_a, req_b, mul_p,
    output gnt, mul_a, mul_b, res_valid, res_id, res_p
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one fixed-latency multiplier among N_REQ requesters,
// with an ID tag pipe aligned to the multiplier and a hold/drain quiesce FSM.
module mult_share_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned W       = 8,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  mult_share_arb_if.slave      bus,
  output logic                 busy,
  output logic                 idle,
  output logic [15:0]          op_cnt
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  tag_t            tag_q [MUL_LAT];
  logic            gnt_en;
  logic            gnt_any;
  logic [ID_W-1:0] gnt_id;
  logic [N_REQ-1:0] gnt_vec;
  int unsigned     idx;
  logic            pipe_busy;
  logic [W-1:0]    a_arr [N_REQ];
  logic [W-1:0]    b_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*W +: W];
    assign b_arr[g] = bus.req_b[g*W +: W];
  end

  // Round-robin search starting at ptr; drives grant and multiplier operands
  always_comb begin
    gnt_en  = !reset && (state_q == RUN) && !hold;
    gnt_any = 1'b0;
    gnt_id  = '0;
    gnt_vec = '0;
    idx     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (gnt_en && !gnt_any && bus.req[ID_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
    gnt_vec[gnt_id] = gnt_any;
    bus.gnt   = gnt_vec;
    bus.mul_a = gnt_any ? a_arr[gnt_id] : '0;
    bus.mul_b = gnt_any ? b_arr[gnt_id] : '0;
  end

  // Any tag stage still carrying a live operation
  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i < MUL_LAT; i++) pipe_busy = pipe_busy | tag_q[i].vld;
  end

  assign busy = pipe_busy | bus.res_valid;
  assign idle = (state_q == HALT);

  // Quiesce FSM next state; releasing hold always wins over drain completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hold) state_d = DRAIN;
      DRAIN:   if (!hold) state_d = RUN;
               else if (!busy) state_d = HALT;
      HALT:    if (!hold) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_any) ptr_q <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  // Tag pipe travelling alongside the multiplier
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: gnt_any, id: gnt_id};
      for (int unsigned i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Result register; id/product hold when nothing returns
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.res_valid <= 1'b0;
      bus.res_id    <= '0;
      bus.res_p     <= '0;
    end else begin
      bus.res_valid <= tag_q[MUL_LAT-1].vld;
      if (tag_q[MUL_LAT-1].vld) begin
        bus.res_id <= tag_q[MUL_LAT-1].id;
        bus.res_p  <= bus.mul_p;
      end
    end
  end

  // Grant counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)        op_cnt <= '0;
    else if (gnt_any) op_cnt <= op_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: latency-1 and latency-3 instances against a queue-based model.
`timescale 1ns/1ps
module tb_mult_share_arb;
  localparam int unsigned N    = 4;
  localparam int unsigned ID_W = 2;
  localparam int unsigned W    = 8;
  localparam int unsigned ND   = 2;

  typedef struct {
    int          k;
    int          due;
    int          id;
    logic [15:0] p;
  } res_t;

  logic clk = 1'b0;
  logic reset, hold;
  always #5 clk = ~clk;

  logic [N-1:0]   req_d [ND];
  logic [N*W-1:0] ra_d  [ND];
  logic [N*W-1:0] rb_d  [ND];
  logic [ND-1:0]  busy_o, idle_o;
  logic [15:0]    opc_o [ND];
  logic [15:0]    mp1;
  logic [15:0]    mp3 [3];

  mult_share_arb_if #(.N_REQ(N), .ID_W(ID_W), .W(W)) bus0 ();
  mult_share_arb_if #(.N_REQ(N), .ID_W(ID_W), .W(W)) bus1 ();

  assign bus0.req = req_d[0];  assign bus0.req_a = ra_d[0];  assign bus0.req_b = rb_d[0];
  assign bus1.req = req_d[1];  assign bus1.req_a = ra_d[1];  assign bus1.req_b = rb_d[1];
  assign bus0.mul_p = mp1;
  assign bus1.mul_p = mp3[2];

  // External multipliers: register operands, deliver product after 1 or 3 cycles
  always @(posedge clk) begin
    mp1    <= 16'(bus0.mul_a) * 16'(bus0.mul_b);
    mp3[0] <= 16'(bus1.mul_a) * 16'(bus1.mul_b);
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end

  mult_share_arb #(.N_REQ(N), .ID_W(ID_W), .W(W), .MUL_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .hold(hold), .bus(bus0),
    .busy(busy_o[0]), .idle(idle_o[0]), .op_cnt(opc_o[0]));

  mult_share_arb #(.N_REQ(N), .ID_W(ID_W), .W(W), .MUL_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(reset), .hold(hold), .bus(bus1),
    .busy(busy_o[1]), .idle(idle_o[1]), .op_cnt(opc_o[1]));

  // Model state (per instance)
  int          n_vec, n_bad, cyc;
  bit          chk_en;
  int          refill_pct;
  logic [N-1:0] refill_mask;
  bit          fixed_ops;
  logic [N-1:0] pend [ND];
  logic [7:0]  opa [ND][N];
  logic [7:0]  opb [ND][N];
  int          m_state [ND];   // 0 run, 1 drain, 2 halt
  int          m_ptr [ND];
  int          m_cnt [ND];
  bit          exp_v [ND];
  int          exp_id [ND];
  logic [15:0] exp_p [ND];
  res_t        scb [$];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive requesters, compare against model, advance model
  task automatic step();
    int g;
    bit mbusy;
    logic [N-1:0] gnt_got;
    logic [7:0] ma_got, mb_got;
    for (int k = 0; k < ND; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[k][i] && refill_mask[i] && ($urandom_range(99) < refill_pct)) begin
          pend[k][i] = 1'b1;
          opa[k][i]  = fixed_ops ? 8'(i + 1) : 8'($urandom);
          opb[k][i]  = fixed_ops ? 8'd3      : 8'($urandom);
        end
        ra_d[k][i*W +: W] = opa[k][i];
        rb_d[k][i*W +: W] = opb[k][i];
      end
      req_d[k] = pend[k];
    end
    #4;
    for (int k = 0; k < ND; k++) begin
      exp_v[k] = 1'b0;
      for (int j = 0; j < scb.size(); j++) begin
        if (scb[j].k == k && scb[j].due == cyc) begin
          exp_v[k] = 1'b1; exp_id[k] = scb[j].id; exp_p[k] = scb[j].p;
          scb.delete(j);
          break;
        end
      end
      mbusy = exp_v[k];
      foreach (scb[j]) if (scb[j].k == k) mbusy = 1'b1;
      g = -1;
      if (!reset && m_state[k] == 0 && !hold) begin
        for (int j = 0; j < N; j++) begin
          if (g < 0 && pend[k][(m_ptr[k] + j) % N]) g = (m_ptr[k] + j) % N;
        end
      end
      gnt_got = (k == 0) ? bus0.gnt   : bus1.gnt;
      ma_got  = (k == 0) ? bus0.mul_a : bus1.mul_a;
      mb_got  = (k == 0) ? bus0.mul_b : bus1.mul_b;
      if (chk_en) begin
        check($sformatf("d%0d c%0d gnt", k, cyc), 32'(gnt_got), (g >= 0) ? (32'd1 << g) : 32'd0);
        check($sformatf("d%0d c%0d mul_a", k, cyc), 32'(ma_got), (g >= 0) ? 32'(opa[k][g]) : 32'd0);
        check($sformatf("d%0d c%0d mul_b", k, cyc), 32'(mb_got), (g >= 0) ? 32'(opb[k][g]) : 32'd0);
        check($sformatf("d%0d c%0d res_valid", k, cyc),
              32'((k == 0) ? bus0.res_valid : bus1.res_valid), 32'(exp_v[k]));
        check($sformatf("d%0d c%0d res_id", k, cyc),
              32'((k == 0) ? bus0.res_id : bus1.res_id), 32'(exp_id[k]));
        check($sformatf("d%0d c%0d res_p", k, cyc),
              32'((k == 0) ? bus0.res_p : bus1.res_p), 32'(exp_p[k]));
        check($sformatf("d%0d c%0d busy", k, cyc), 32'(busy_o[k]), 32'(mbusy));
        check($sformatf("d%0d c%0d idle", k, cyc), 32'(idle_o[k]), 32'(m_state[k] == 2));
        check($sformatf("d%0d c%0d op_cnt", k, cyc), 32'(opc_o[k]), 32'(m_cnt[k]));
      end
      if (reset) begin
        m_state[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
        exp_v[k] = 1'b0; exp_id[k] = 0; exp_p[k] = '0;
        for (int j = scb.size() - 1; j >= 0; j--) if (scb[j].k == k) scb.delete(j);
      end else begin
        if (g >= 0) begin
          scb.push_back('{k: k, due: cyc + lat_of(k) + 1, id: g,
                          p: 16'(opa[k][g]) * 16'(opb[k][g])});
          pend[k][g] = 1'b0;
          m_ptr[k] = (g + 1) % N;
          m_cnt[k] = (m_cnt[k] + 1) % 65536;
        end
        case (m_state[k])
          0: if (hold) m_state[k] = 1;
          1: if (!hold) m_state[k] = 0; else if (!mbusy) m_state[k] = 2;
          default: if (!hold) m_state[k] = 0;
        endcase
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_pend(input logic [N-1:0] m, input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < ND; k++) begin
      pend[k] = m;
      for (int i = 0; i < N; i++) begin
        if (m[i]) begin opa[k][i] = a; opb[k][i] = b; end
      end
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0; chk_en = 1'b0;
    refill_pct = 0; refill_mask = '0; fixed_ops = 1'b0;
    for (int k = 0; k < ND; k++) begin
      pend[k] = '0; m_state[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
      exp_v[k] = 1'b0; exp_id[k] = 0; exp_p[k] = '0;
      for (int i = 0; i < N; i++) begin opa[k][i] = '0; opb[k][i] = '0; end
    end
    reset = 1'b1; hold = 1'b0;
    @(posedge clk); #1;
    step(); step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;

    // Single op 0xFF*0xFF from requester 0
    set_pend(4'b0001, 8'hFF, 8'hFF);
    step(); step();
    check("t1 res_p", 32'(bus0.res_p), 32'hFE01);
    check("t1 op_cnt", 32'(opc_o[0]), 32'd1);
    step(); step();

    // All four requesting, a_i = i+1, b = 3
    fixed_ops = 1'b1; refill_mask = 4'b1111; refill_pct = 100;
    repeat (8) step();
    refill_pct = 0; fixed_ops = 1'b0;
    repeat (5) step();

    // Only requesters 0 and 2
    refill_mask = 4'b0101; refill_pct = 100;
    repeat (8) step();
    refill_pct = 0;
    repeat (5) step();

    // Hold with one op in flight, then release
    set_pend(4'b0001, 8'h12, 8'h34);
    step();
    hold = 1'b1;
    set_pend(4'b0010, 8'h56, 8'h78);
    repeat (5) step();
    check("t4 idle", 32'(idle_o[0]), 32'd1);
    hold = 1'b0;
    repeat (4) step();

    // Reset while a result is due next cycle
    set_pend(4'b0001, 8'h9A, 8'hBC);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_pend(4'b1000, 8'h11, 8'h22);
    check("t5 res_valid", 32'(bus0.res_valid), 32'd0);
    check("t5 op_cnt", 32'(opc_o[0]), 32'd0);
    repeat (5) step();

    // Random traffic with occasional hold and reset
    refill_mask = 4'b1111; refill_pct = 50;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(99) < 8) hold = ~hold;
      reset = ($urandom_range(299) == 0);
      step();
    end
    reset = 1'b0; hold = 1'b0;
    refill_pct = 0;
    repeat (6) step();

    // 65536 back-to-back grants: counter wraps to zero
    reset = 1'b1;
    step();
    reset = 1'b0;
    refill_pct = 100;
    repeat (65536) step();
    check("wrap op_cnt l1", 32'(opc_o[0]), 32'd0);
    check("wrap op_cnt l3", 32'(opc_o[1]), 32'd0);
    refill_pct = 0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
